// File: rtl/div_pkg.sv
// Shared definitions for the restoring shift-and-subtract divider.
//
// Contents:
//   DEFAULT_WIDTH  default operand width (divisor/quotient/remainder)
//   state_t        controller states IDLE, RUN, DONE
//   count_width()  width of the iteration counter for a given WIDTH
package div_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_COUNT_W = $clog2(DEFAULT_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter runs 0..WIDTH-1. It must be at least one bit wide, even for degenerate widths.
   function automatic int count_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_sub_divider.sv
// Iterative restoring divider that produces one quotient bit per clock.
// It divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor. The dividend is
// typically a product from the shift-and-add multiplier.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   on         start request; only honoured in IDLE
//   dividend   2*WIDTH-bit numerator, captured on the start edge
//   divisor    WIDTH-bit denominator, captured on the start edge
//   quotient   registered WIDTH-bit result
//   remainder  registered WIDTH-bit result
//   busy       high while iterating (RUN)
//   done       one-cycle pulse when the result is valid (DONE)
//   dbz        divide-by-zero flag for the last operation
//   ovf        quotient-overflow flag for the last operation
module shift_sub_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 on,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 busy,
   output logic                 done,
   output logic                 dbz,
   output logic                 ovf
);

   localparam int CW = count_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state_reg, state_next;

   logic [WIDTH:0]   r_reg;        // partial remainder, one guard bit
   logic [WIDTH-1:0] q_reg;        // low dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] divisor_reg;
   logic [CW-1:0]    count_reg;

   logic [WIDTH-1:0] dividend_hi;
   logic             start;
   logic             zero_div;
   logic             overflow;

   assign dividend_hi = dividend[2*WIDTH-1:WIDTH];
   assign start       = (state_reg == IDLE) && on;
   assign zero_div    = (divisor == '0);
   // If the upper half is already at least the divisor, the quotient needs more than WIDTH bits.
   assign overflow    = (dividend_hi >= divisor);

   // Single restoring step.
   // R < divisor holds before each shift, so the shifted R is less than 2*divisor and fits in WIDTH+1 bits.
   // The trial difference is therefore negative exactly when its top bit is set.
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   r_step;
   logic [WIDTH-1:0] q_step;
   logic             take;

   always_comb begin
      r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      trial   = r_shift - {1'b0, divisor_reg};
      take    = ~trial[WIDTH];
      r_step  = take ? trial : r_shift;
      q_step  = {q_reg[WIDTH-2:0], take};
   end

   // Controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (on) begin
               state_next = (zero_div || overflow) ? DONE : RUN;
            end
         end
         RUN: begin
            if (count_reg == LAST) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg       <= '0;
         q_reg       <= '0;
         divisor_reg <= '0;
         count_reg   <= '0;
         quotient    <= '0;
         remainder   <= '0;
         dbz         <= 1'b0;
         ovf         <= 1'b0;
      end else if (start) begin
         divisor_reg <= divisor;
         count_reg   <= '0;
         dbz         <= 1'b0;
         ovf         <= 1'b0;
         if (zero_div) begin
            quotient  <= '1;
            remainder <= dividend[WIDTH-1:0];
            dbz       <= 1'b1;
         end else if (overflow) begin
            quotient  <= '1;
            remainder <= '0;
            ovf       <= 1'b1;
         end else begin
            r_reg <= {1'b0, dividend_hi};
            q_reg <= dividend[WIDTH-1:0];
         end
      end else if (state_reg == RUN) begin
         r_reg     <= r_step;
         q_reg     <= q_step;
         count_reg <= count_reg + 1'b1;
         if (count_reg == LAST) begin
            quotient  <= q_step;
            remainder <= r_step[WIDTH-1:0];
         end
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);

endmodule
